vga_box_overlay: RTL

- Pixel-pipeline stage directly downstream of the VGA timing/colour-bar generator.
- Consumes that generator's sync, data-enable and background RGB stream.
- Overlays a solid square that moves by a fixed step once per frame and bounces off the active-area edges.
- Emits delay-matched sync, data-enable and RGB to the VGA DAC pins.

---
 rtl/vga_pkg.sv | 32 +++
 rtl/vga_box_overlay_if.sv | 22 ++
 rtl/vga_pos_tracker.sv | 41 ++++
 rtl/vga_box_overlay.sv | 80 ++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA constants, colours, pixel/coordinate types and axis helpers.
// Contents: timing constants and sync polarities, rgb888_t, coord_t,
// saturating increment, span test and one-axis bounce step.
package vga_pkg;
    localparam int H_ACTIVE = 1024;
    localparam int V_ACTIVE = 768;
    localparam logic HS_POL = 1'b0;
    localparam logic VS_POL = 1'b0;
    typedef logic [11:0] coord_t;
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;
    localparam rgb888_t WHITE  = '{r: 8'hff, g: 8'hff, b: 8'hff};
    localparam rgb888_t RED    = '{r: 8'hff, g: 8'h00, b: 8'h00};
    localparam rgb888_t PURPLE = '{r: 8'ha0, g: 8'h20, b: 8'hf0};
    localparam rgb888_t BLACK  = '{r: 8'h00, g: 8'h00, b: 8'h00};
    function automatic coord_t sat_inc(coord_t c);
        return (c == '1) ? c : c + 12'd1;
    endfunction
    // 13-bit compare so lo + size cannot overflow.
    function automatic logic in_span(coord_t p, coord_t lo, int size);
        return ({1'b0, p} >= {1'b0, lo}) && ({1'b0, p} < {1'b0, lo} + 13'(size));
    endfunction
    // Returns {dir, pos}, dir 1 = increasing; clamps at either edge and reverses.
    function automatic logic [12:0] bounce(coord_t pos, logic fwd, int limit, int size, int step);
        if (fwd)
            return ({1'b0, pos} + 13'(size + step) > 13'(limit)) ? {1'b0, 12'(limit - size)} : {1'b1, pos + 12'(step)};
        return ({1'b0, pos} < 13'(step)) ? {1'b1, 12'd0} : {1'b0, pos - 12'(step)};
    endfunction
endpackage

// File: rtl/vga_box_overlay_if.sv
// vga_box_overlay_if: pixel stream from timing generator through the overlay to the DAC.
// Inputs: in_hs/in_vs/in_de sync and data-enable, in_r/g/b background, enable.
// Outputs: out_hs/out_vs/out_de/out_r/g/b, box_x/box_y position, frame_tick.
// master = timing-generator side, slave = overlay side.
interface vga_box_overlay_if;
    import vga_pkg::*;
    logic       in_hs, in_vs, in_de;
    logic [7:0] in_r, in_g, in_b;
    logic       enable;
    logic       out_hs, out_vs, out_de;
    logic [7:0] out_r, out_g, out_b;
    coord_t     box_x, box_y;
    logic       frame_tick;
    modport master (
        output in_hs, in_vs, in_de, in_r, in_g, in_b, enable,
        input  out_hs, out_vs, out_de, out_r, out_g, out_b, box_x, box_y, frame_tick
    );
    modport slave (
        input  in_hs, in_vs, in_de, in_r, in_g, in_b, enable,
        output out_hs, out_vs, out_de, out_r, out_g, out_b, box_x, box_y, frame_tick
    );
endinterface

// File: rtl/vga_pos_tracker.sv
// vga_pos_tracker: tracks the x/y of the current data-enable pixel and flags each frame start.
// Ports: clk, rst; de_i, vs_i from the timing generator;
// x_o/y_o current pixel coordinates (saturating); frame_tick_o one-cycle pulse per vsync leading edge.
module vga_pos_tracker
    import vga_pkg::*;
#(
    parameter logic VS_POL = vga_pkg::VS_POL
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   de_i,
    input  logic   vs_i,
    output coord_t x_o,
    output coord_t y_o,
    output logic   frame_tick_o
);
    logic   de_q, vs_q, tick_q, vs_lead;
    coord_t x_q, x_d, y_q, y_d;
    assign vs_lead = (vs_i == VS_POL) && (vs_q != VS_POL);
    assign x_d = de_i ? sat_inc(x_q) : '0;
    // Frame clear beats the line increment when both land together.
    assign y_d = vs_lead ? '0 : (de_q && !de_i) ? sat_inc(y_q) : y_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            de_q   <= 1'b0;
            vs_q   <= ~VS_POL;
            tick_q <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
        end else begin
            de_q   <= de_i;
            vs_q   <= vs_i;
            tick_q <= vs_lead;
            x_q    <= x_d;
            y_q    <= y_d;
        end
    end
    assign x_o = x_q;
    assign y_o = y_q;
    assign frame_tick_o = tick_q;
endmodule

// File: rtl/vga_box_overlay.sv
// vga_box_overlay: overlays a bouncing solid square on the background pixel stream.
// Ports: clk, rst (sync, active high); bus (slave) carries in_* sync/de/rgb and enable,
// out_* delayed 2 cycles, box_x/box_y top-left corner, frame_tick.
module vga_box_overlay
    import vga_pkg::*;
#(
    parameter int         H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int         V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int         BOX_SIZE = 100,
    parameter int         STEP     = 2,
    parameter int         X0       = 462,
    parameter int         Y0       = 334,
    parameter logic       HS_POL   = vga_pkg::HS_POL,
    parameter logic       VS_POL   = vga_pkg::VS_POL,
    parameter logic [7:0] BOX_R    = 8'ha0,
    parameter logic [7:0] BOX_G    = 8'h20,
    parameter logic [7:0] BOX_B    = 8'hf0
) (
    input logic              clk,
    input logic              rst,
    vga_box_overlay_if.slave bus
);
    localparam rgb888_t BOX = '{r: BOX_R, g: BOX_G, b: BOX_B};
    coord_t  x_cnt, y_cnt, bx_q, bx_d, by_q, by_d;
    logic    tick, dx_q, dx_d, dy_q, dy_d, hit_d;
    logic    hs1_q, vs1_q, de1_q, hit1_q, hs2_q, vs2_q, de2_q;
    rgb888_t rgb1_q, rgb2_q, rgb_d;
    vga_pos_tracker #(.VS_POL(VS_POL)) u_pos (
        .clk          (clk),
        .rst          (rst),
        .de_i         (bus.in_de),
        .vs_i         (bus.in_vs),
        .x_o          (x_cnt),
        .y_o          (y_cnt),
        .frame_tick_o (tick)
    );
    // Motion only at frame start, so the box is stable across the whole active region.
    assign {dx_d, bx_d} = (tick && bus.enable) ? bounce(bx_q, dx_q, H_ACTIVE, BOX_SIZE, STEP) : {dx_q, bx_q};
    assign {dy_d, by_d} = (tick && bus.enable) ? bounce(by_q, dy_q, V_ACTIVE, BOX_SIZE, STEP) : {dy_q, by_q};
    assign hit_d = bus.in_de && bus.enable && in_span(x_cnt, bx_q, BOX_SIZE) && in_span(y_cnt, by_q, BOX_SIZE);
    assign rgb_d = !de1_q ? BLACK : hit1_q ? BOX : rgb1_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            bx_q   <= coord_t'(X0);
            by_q   <= coord_t'(Y0);
            dx_q   <= 1'b1;
            dy_q   <= 1'b1;
            hs1_q  <= ~HS_POL;
            vs1_q  <= ~VS_POL;
            de1_q  <= 1'b0;
            hit1_q <= 1'b0;
            rgb1_q <= BLACK;
            hs2_q  <= ~HS_POL;
            vs2_q  <= ~VS_POL;
            de2_q  <= 1'b0;
            rgb2_q <= BLACK;
        end else begin
            bx_q   <= bx_d;
            by_q   <= by_d;
            dx_q   <= dx_d;
            dy_q   <= dy_d;
            hs1_q  <= bus.in_hs;
            vs1_q  <= bus.in_vs;
            de1_q  <= bus.in_de;
            hit1_q <= hit_d;
            rgb1_q <= {bus.in_r, bus.in_g, bus.in_b};
            hs2_q  <= hs1_q;
            vs2_q  <= vs1_q;
            de2_q  <= de1_q;
            rgb2_q <= rgb_d;
        end
    end
    assign bus.out_hs = hs2_q;
    assign bus.out_vs = vs2_q;
    assign bus.out_de = de2_q;
    assign {bus.out_r, bus.out_g, bus.out_b} = rgb2_q;
    assign bus.box_x = bx_q;
    assign bus.box_y = by_q;
    assign bus.frame_tick = tick;
endmodule
